// File: rtl/regfile_sb.sv
// Register file with per-entry busy scoreboard and a power-up clear sweep.
// Optional write-through bypass: define REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                alloc,
    input  logic [AW-1:0]       alloc_addr
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              w_wr_ok;
    logic              w_al_ok;

    // True for an address that maps to a real, writable entry.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign ready   = (r_state == S_RUN);
    assign w_wr_ok = ready && we && addr_ok(wa);
    assign w_al_ok = ready && alloc && addr_ok(alloc_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR)
                r_cnt <= r_cnt + AW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_CLEAR && r_cnt == AW'(DEPTH - 1))
            w_state_nxt = S_RUN;
    end

    // Storage is not reset; the sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR)
            r_mem[r_cnt] <= '0;
        else if (w_wr_ok)
            r_mem[wa] <= wd;
    end

    // Alloc is applied after the write clear so a same-address alloc keeps the bit set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            if (w_wr_ok)
                r_busy[wa] <= 1'b0;
            if (w_al_ok)
                r_busy[alloc_addr] <= 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (ready && addr_ok(ra[i*AW +: AW])) begin
                rdata[i*XLEN +: XLEN] = r_mem[ra[i*AW +: AW]];
                rbusy[i]              = r_busy[ra[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                if (we && wa == ra[i*AW +: AW]) begin
                    rdata[i*XLEN +: XLEN] = wd;
                    rbusy[i]              = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: integer bank (default params) and FP bank (NRD=3, ZERO_REG=0).
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_errors = 0;

    // Integer bank
    logic        ready;
    logic [9:0]  ra;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        alloc;
    logic [4:0]  alloc_addr;

    // FP bank
    logic        fp_ready;
    logic [14:0] fp_ra;
    logic [95:0] fp_rdata;
    logic [2:0]  fp_rbusy;
    logic        fp_we;
    logic [4:0]  fp_wa;
    logic [31:0] fp_wd;
    logic        fp_alloc;
    logic [4:0]  fp_alloc_addr;

    regfile_sb dut (
        .clk(clk), .rst(rst), .ready(ready), .ra(ra), .rdata(rdata), .rbusy(rbusy),
        .we(we), .wa(wa), .wd(wd), .alloc(alloc), .alloc_addr(alloc_addr)
    );

    regfile_sb #(.NRD(3), .ZERO_REG(0)) dut_fp (
        .clk(clk), .rst(rst), .ready(fp_ready), .ra(fp_ra), .rdata(fp_rdata), .rbusy(fp_rbusy),
        .we(fp_we), .wa(fp_wa), .wd(fp_wd), .alloc(fp_alloc), .alloc_addr(fp_alloc_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_and_check(input string name);
        for (int e = 1; e <= 32; e++) begin
            tick();
            n_checks++;
            if (ready !== (e == 32)) begin
                n_errors++;
                $display("FAIL %s ready edge %0d: got %b want %b", name, e, ready, (e == 32));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; we = 0; wa = 0; wd = 0; alloc = 0; alloc_addr = 0; ra = 0;
        fp_we = 0; fp_wa = 0; fp_wd = 0; fp_alloc = 0; fp_alloc_addr = 0; fp_ra = 0;
        repeat (3) tick();
        n_checks++;
        if ({ready, rbusy, rdata} !== '0) begin
            n_errors++;
            $display("FAIL reset_state: ready=%b rbusy=%b rdata=%h want all 0", ready, rbusy, rdata);
        end
        rst = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            if (e == 10) begin we = 1; wa = 5'd5; wd = 32'hDEAD; end
            tick();
            we = 0;
            n_checks++;
            if (ready !== (e == 32)) begin
                n_errors++;
                $display("FAIL clear_ready edge %0d: got %b want %b", e, ready, (e == 32));
            end
        end
        n_checks++;
        if (fp_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL fp_ready: got %b want 1", fp_ready);
        end
        for (int a = 0; a < 32; a++) begin
            ra = {5'(31 - a), 5'(a)};
            #1;
            n_checks++;
            if ({rbusy, rdata} !== '0) begin
                n_errors++;
                $display("FAIL cleared_reg %0d: rbusy=%b rdata=%h want 0", a, rbusy, rdata);
            end
        end
    endtask

    task automatic test_basic_rw();
        we = 1; wa = 5'd7; wd = 32'h12345678;
        tick();
        wa = 5'd31; wd = 32'hCAFEBABE; ra = {5'd0, 5'd7};
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'h12345678) begin
            n_errors++;
            $display("FAIL write_x7: got %h want 12345678", rdata[31:0]);
        end
        tick();
        we = 0; ra = {5'd31, 5'd7};
        #1;
        n_checks++;
        if (rdata !== {32'hCAFEBABE, 32'h12345678}) begin
            n_errors++;
            $display("FAIL read_x7_x31: got %h want cafebabe12345678", rdata);
        end
    endtask

    task automatic test_zero_reg();
        we = 1; wa = 5'd0; wd = 32'hFFFFFFFF;
        alloc = 1; alloc_addr = 5'd0;
        tick();
        we = 0; alloc = 0; ra = {5'd0, 5'd0};
        #1;
        n_checks++;
        if ({rbusy, rdata} !== '0) begin
            n_errors++;
            $display("FAIL zero_reg: rbusy=%b rdata=%h want 0", rbusy, rdata);
        end
    endtask

    task automatic test_scoreboard();
        alloc = 1; alloc_addr = 5'd3; ra = {5'd0, 5'd3};
        #1;
        n_checks++;
        if (rbusy[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_before_alloc: got %b want 0", rbusy[0]);
        end
        tick();
        alloc = 0;
        #1;
        n_checks++;
        if (rbusy[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_after_alloc: got %b want 1", rbusy[0]);
        end
        we = 1; wa = 5'd3; wd = 32'h55;
        tick();
        we = 0;
        #1;
        n_checks++;
        if (rbusy[0] !== 1'b0 || rdata[31:0] !== 32'h55) begin
            n_errors++;
            $display("FAIL busy_clear_on_write: rbusy=%b rdata=%h want 0/00000055", rbusy[0], rdata[31:0]);
        end
        we = 1; wa = 5'd4; wd = 32'hAA; alloc = 1; alloc_addr = 5'd4;
        tick();
        we = 0; alloc = 0; ra = {5'd4, 5'd4};
        #1;
        n_checks++;
        if (rdata !== {32'hAA, 32'hAA} || rbusy !== 2'b11) begin
            n_errors++;
            $display("FAIL alloc_write_same: rdata=%h rbusy=%b want 000000aa000000aa/11", rdata, rbusy);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_d;
        logic        exp_b;
        we = 1; wa = 5'd9; wd = 32'h1111;
        tick();
        we = 0; alloc = 1; alloc_addr = 5'd9;
        tick();
        alloc = 0;
        we = 1; wa = 5'd9; wd = 32'h9999; ra = {5'd0, 5'd9};
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'h9999; exp_b = 1'b0;
`else
        exp_d = 32'h1111; exp_b = 1'b1;
`endif
        #1;
        n_checks++;
        if (rdata[31:0] !== exp_d || rbusy[0] !== exp_b) begin
            n_errors++;
            $display("FAIL bypass_same_cycle: rdata=%h rbusy=%b want %h/%b", rdata[31:0], rbusy[0], exp_d, exp_b);
        end
        tick();
        we = 0;
        #1;
        n_checks++;
        if (rdata[31:0] !== 32'h9999 || rbusy[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL bypass_next_cycle: rdata=%h rbusy=%b want 00009999/0", rdata[31:0], rbusy[0]);
        end
    endtask

    task automatic test_fp();
        fp_we = 1; fp_wa = 5'd0; fp_wd = 32'h3F800000;
        tick();
        fp_we = 0; fp_ra = '0;
        #1;
        n_checks++;
        if (fp_rdata !== {3{32'h3F800000}} || fp_rbusy !== 3'b000) begin
            n_errors++;
            $display("FAIL fp_f0_read: rdata=%h rbusy=%b want 3f800000 x3/000", fp_rdata, fp_rbusy);
        end
        fp_alloc = 1; fp_alloc_addr = 5'd0;
        tick();
        fp_alloc = 0;
        #1;
        n_checks++;
        if (fp_rbusy !== 3'b111) begin
            n_errors++;
            $display("FAIL fp_f0_busy: got %b want 111", fp_rbusy);
        end
    endtask

    task automatic test_reset_run();
        alloc = 1; alloc_addr = 5'd10;
        tick();
        alloc = 0; ra = {5'd4, 5'd10};
        #1;
        n_checks++;
        if (rbusy !== 2'b11) begin
            n_errors++;
            $display("FAIL busy_before_reset: got %b want 11", rbusy);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b0 || rbusy !== 2'b00 || rdata !== '0) begin
            n_errors++;
            $display("FAIL async_reset_run: ready=%b rbusy=%b rdata=%h want 0", ready, rbusy, rdata);
        end
        tick();
        rst = 1'b1;
        sweep_and_check("run_resweep");
        #1;
        n_checks++;
        if (rbusy !== 2'b00 || rdata !== '0) begin
            n_errors++;
            $display("FAIL busy_cleared_after_reset: rbusy=%b rdata=%h want 0", rbusy, rdata);
        end
        fp_ra = '0;
        #1;
        n_checks++;
        if (fp_rbusy !== 3'b000 || fp_rdata !== '0) begin
            n_errors++;
            $display("FAIL fp_cleared_after_reset: rbusy=%b rdata=%h want 0", fp_rbusy, fp_rdata);
        end
    endtask

    task automatic test_reset_mid_sweep();
        we = 1; wa = 5'd31; wd = 32'hCAFEBABE;
        tick();
        we = 0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (20) tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_sweep_ready: got %b want 0", ready);
        end
        tick();
        rst = 1'b1;
        sweep_and_check("mid_sweep_restart");
        ra = {5'd7, 5'd31};
        #1;
        n_checks++;
        if (rdata !== '0) begin
            n_errors++;
            $display("FAIL mid_sweep_cleared: got %h want 0", rdata);
        end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_zero_reg();
        test_scoreboard();
        test_bypass();
        test_fp();
        test_reset_run();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
